csi_packet_parser: RTL and testbench
====================================

CSI_PACKET_PARSER -- requirements
Module: csi_packet_parser

Interface
REQ-001 Parameter VC_ID, default 2'd0: virtual channel accepted when the filter is enabled.
REQ-002 Parameter DT_PIXEL, default 6'h2B: long-packet data type forwarded downstream (RAW10).
REQ-003 rxbyteclkhs  in  1: byte clock, sole clock, all flops on posedge.
REQ-004 reset_n  in  1: asynchronous active-low reset.
REQ-005 data_in  in  16: lane-merged bytes, [15:8] first byte, [7:0] second byte.
REQ-006 data_valid  in  1: high for every cycle of an HS burst; low between packets.
REQ-007 data_out  out  16: payload word, same byte order as data_in.
REQ-008 frame_active  out  1: high exactly on cycles where data_out carries payload of an accepted pixel packet.
REQ-009 frame_valid  out  1: high from Frame Start to Frame End short packet.
REQ-010 line_count  out  16: accepted pixel lines since Frame Start.
REQ-011 err_wc  out  1: one-cycle pulse, pixel packet rejected for WC zero or odd.
REQ-012 err_abort  out  1: one-cycle pulse, data_valid dropped before payload plus CRC completed.

Function
REQ-013 Header captured over two valid cycles: cycle H1 = {DI, WC[7:0]}, cycle H2 = {WC[15:8], ECC}; DI = {VC[7:6], DT[5:0]}.
REQ-014 FSM states: IDLE, HDR2, PAYLOAD, CRC, DRAIN.
REQ-015 IDLE: data_valid high -> latch DI and WC low byte, go HDR2; otherwise stay.
REQ-016 HDR2: data_valid high -> latch WC high byte and decode; data_valid low -> err_abort pulse, go IDLE.
REQ-017 Decode DT 0x00 (Frame Start): frame_valid set next cycle, line_count cleared to 0, go DRAIN.
REQ-018 Decode DT 0x01 (Frame End): frame_valid cleared next cycle, go DRAIN.
REQ-019 Decode DT equal to DT_PIXEL with WC nonzero and even: go PAYLOAD, word counter loaded with WC/2.
REQ-020 Decode DT_PIXEL with WC zero or odd: err_wc pulse, go DRAIN, no payload forwarded.
REQ-021 Any other DT: go DRAIN, nothing forwarded.
REQ-022 PAYLOAD: each cycle with data_valid high forwards data_in to data_out with frame_active high one cycle later, and decrements the counter; on the last word go CRC.
REQ-023 Latency data_in to data_out/frame_active: exactly 1 cycle; payload frame_active strictly contiguous for WC/2 cycles.
REQ-024 CRC: consumes one 16-bit word (not forwarded), increments line_count (wraps 0xFFFF -> 0), go DRAIN.
REQ-025 DRAIN: stay while data_valid high; go IDLE on first data_valid low cycle.
REQ-026 data_valid low in PAYLOAD or CRC: err_abort pulse, frame_active low next cycle, line_count not incremented, go IDLE.
REQ-027 data_out SHALL be 16'h0000 whenever frame_active is low.
REQ-028 Frame Start while frame_valid already high: line_count re-cleared, frame_valid stays high; Frame End while low: no effect.
REQ-029 Pixel packets are accepted regardless of frame_valid.

Reset
REQ-030 reset_n low: FSM IDLE, data_out 0, frame_active 0, frame_valid 0, line_count 0, err_wc 0, err_abort 0, word counter 0.
REQ-031 reset_n assertion mid-packet takes effect immediately; after deassertion the remainder of the burst is not forwarded, since the FSM starts in IDLE and treats the next valid word as a header.

Configuration
REQ-032 Macro CSI_VC_FILTER_EN defined: packets whose VC differs from VC_ID (Frame Start/End included) go to DRAIN with no output or flag effect.
REQ-033 Macro CSI_VC_FILTER_EN undefined: VC bits ignored; all virtual channels processed identically.

Verification
REQ-034 FS burst {0x0000,0x00xx}, gap -> frame_valid=1, line_count=0; FE burst -> frame_valid=0.
REQ-035 Pixel packet DI=0x2B WC=10, 5 payload words A1A2..E1E2 plus CRC -> frame_active high 5 contiguous cycles, 1 cycle after input, data_out=payload words, line_count 0->1.
REQ-036 DI=0x2B WC=9 -> err_wc single pulse, frame_active never high, line_count unchanged.
REQ-037 WC=10, data_valid dropped after 3rd payload word -> 3 forwarded words, err_abort pulse, line_count unchanged, next packet parsed normally.
REQ-038 With CSI_VC_FILTER_EN and VC_ID=0: pixel packet DI=0x6B (VC=1) -> no forwarding; same packet with DI=0x2B -> forwarded.
REQ-039 reset_n pulsed low during PAYLOAD -> all outputs 0 asynchronously; the following burst is parsed from its first word as a header.

Source files
------------

// File: rtl/csi_packet_parser_if.sv
// Byte-clock bus between the CSI-2 lane merger (master) and the packet parser (slave).
interface csi_packet_parser_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic [15:0] data_out;
    logic        frame_active;
    logic        frame_valid;
    logic [15:0] line_count;
    logic        err_wc;
    logic        err_abort;

    modport master (
        output data_in, data_valid,
        input  data_out, frame_active, frame_valid, line_count, err_wc, err_abort
    );

    modport slave (
        input  data_in, data_valid,
        output data_out, frame_active, frame_valid, line_count, err_wc, err_abort
    );
endinterface

// File: rtl/csi_packet_parser.sv
// CSI-2 packet parser: forwards pixel payload words and tracks frame/line state.
// Optional macro CSI_VC_FILTER_EN restricts processing to virtual channel VC_ID.
module csi_packet_parser #(
    parameter logic [1:0] VC_ID    = 2'd0,
    parameter logic [5:0] DT_PIXEL = 6'h2B
) (
    input logic                rxbyteclkhs,
    input logic                reset_n,
    csi_packet_parser_if.slave csi
);
    typedef enum logic [2:0] {IDLE, HDR2, PAYLOAD, CRC, DRAIN} state_t;

    state_t      state;
    logic [7:0]  di_q;
    logic [7:0]  wc_lo_q;
    logic [14:0] word_cnt;
    logic [15:0] wc;
    logic [5:0]  dt;
    logic        vc_ok;

    // The word count high byte arrives in the same cycle it is decoded.
    assign wc = {csi.data_in[15:8], wc_lo_q};
    assign dt = di_q[5:0];

`ifdef CSI_VC_FILTER_EN
    assign vc_ok = (di_q[7:6] == VC_ID);
`else
    logic unused_vc;
    assign unused_vc = ^{di_q[7:6], VC_ID};
    assign vc_ok     = 1'b1;
`endif

    always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            di_q             <= '0;
            wc_lo_q          <= '0;
            word_cnt         <= '0;
            csi.data_out     <= '0;
            csi.frame_active <= 1'b0;
            csi.frame_valid  <= 1'b0;
            csi.line_count   <= '0;
            csi.err_wc       <= 1'b0;
            csi.err_abort    <= 1'b0;
        end else begin
            csi.data_out     <= '0;
            csi.frame_active <= 1'b0;
            csi.err_wc       <= 1'b0;
            csi.err_abort    <= 1'b0;
            case (state)
                IDLE: begin
                    if (csi.data_valid) begin
                        di_q    <= csi.data_in[15:8];
                        wc_lo_q <= csi.data_in[7:0];
                        state   <= HDR2;
                    end
                end
                HDR2: begin
                    if (!csi.data_valid) begin
                        csi.err_abort <= 1'b1;
                        state         <= IDLE;
                    end else if (!vc_ok) begin
                        state <= DRAIN;
                    end else if (dt == 6'h00) begin
                        csi.frame_valid <= 1'b1;
                        csi.line_count  <= '0;
                        state           <= DRAIN;
                    end else if (dt == 6'h01) begin
                        csi.frame_valid <= 1'b0;
                        state           <= DRAIN;
                    end else if (dt == DT_PIXEL) begin
                        if (wc != 16'h0000 && !wc[0]) begin
                            word_cnt <= wc[15:1];
                            state    <= PAYLOAD;
                        end else begin
                            csi.err_wc <= 1'b1;
                            state      <= DRAIN;
                        end
                    end else begin
                        state <= DRAIN;
                    end
                end
                PAYLOAD: begin
                    if (csi.data_valid) begin
                        csi.data_out     <= csi.data_in;
                        csi.frame_active <= 1'b1;
                        word_cnt         <= word_cnt - 15'd1;
                        if (word_cnt == 15'd1) begin
                            state <= CRC;
                        end
                    end else begin
                        csi.err_abort <= 1'b1;
                        word_cnt      <= '0;
                        state         <= IDLE;
                    end
                end
                CRC: begin
                    if (csi.data_valid) begin
                        csi.line_count <= csi.line_count + 16'd1;
                        state          <= DRAIN;
                    end else begin
                        csi.err_abort <= 1'b1;
                        state         <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!csi.data_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csi_packet_parser.sv
// Testbench for csi_packet_parser: table-driven packets, reset corner case and randomized bursts
// checked cycle by cycle against a packet-level reference model.
module tb_csi_packet_parser;
    localparam logic [1:0] VC_ID    = 2'd0;
    localparam logic [5:0] DT_PIXEL = 6'h2B;

    logic rxbyteclkhs = 1'b0;
    logic reset_n;

    csi_packet_parser_if bus();

    csi_packet_parser #(.VC_ID(VC_ID), .DT_PIXEL(DT_PIXEL)) dut (
        .rxbyteclkhs (rxbyteclkhs),
        .reset_n     (reset_n),
        .csi         (bus.slave)
    );

    always #5 rxbyteclkhs = ~rxbyteclkhs;

    typedef struct packed {
        logic [0:7][15:0] w;
        int               n;
        logic             exp_fv;
        logic [15:0]      exp_lc;
        int               exp_fa;
        int               exp_ew;
        int               exp_ea;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] burst_q[$];
    logic        model_fv;
    logic [15:0] model_lc;
    int          seen_fa, seen_ew, seen_ea;
    vec_t        vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [0:7][15:0] w, input int n, input logic fv,
                                input logic [15:0] lc, input int fa, input int ew, input int ea);
        vec_t v;
        v.w = w; v.n = n; v.exp_fv = fv; v.exp_lc = lc;
        v.exp_fa = fa; v.exp_ew = ew; v.exp_ea = ea;
        return v;
    endfunction

    function automatic logic vc_pass(input logic [7:0] di);
`ifdef CSI_VC_FILTER_EN
        return di[7:6] == VC_ID;
`else
        return 1'b1;
`endif
    endfunction

    // Called at a negedge; drives burst_q then 'gap' idle cycles and returns at a negedge.
    // Expected output at index j is what should be visible right after the edge that samples input j.
    task automatic applyStimulus(input int gap);
        int          n;
        int          p;
        logic [7:0]  di;
        logic [15:0] wc;
        logic [5:0]  dt;
        logic        acc, exp_fa, exp_ew, exp_ea;
        logic [15:0] exp_do;
        n = burst_q.size();
        seen_fa = 0; seen_ew = 0; seen_ea = 0;
        for (int j = 0; j < n + gap; j++) begin
            if (j < n) begin
                bus.data_valid = 1'b1;
                bus.data_in    = burst_q[j];
            end else begin
                bus.data_valid = 1'b0;
                bus.data_in    = 16'($urandom);
            end
            @(posedge rxbyteclkhs);
            #1;
            exp_fa = 1'b0; exp_do = '0; exp_ew = 1'b0; exp_ea = 1'b0;
            if (n == 1 && j == 1) exp_ea = 1'b1;
            if (n >= 2) begin
                di  = burst_q[0][15:8];
                wc  = {burst_q[1][15:8], burst_q[0][7:0]};
                dt  = di[5:0];
                acc = vc_pass(di);
                if (acc && dt == 6'h00) begin
                    if (j == 1) begin model_fv = 1'b1; model_lc = '0; end
                end else if (acc && dt == 6'h01) begin
                    if (j == 1) model_fv = 1'b0;
                end else if (acc && dt == DT_PIXEL) begin
                    if (wc == 0 || wc[0]) begin
                        if (j == 1) exp_ew = 1'b1;
                    end else begin
                        p = int'(wc) / 2;
                        if (j >= 2 && j <= 1 + p && j < n) begin
                            exp_fa = 1'b1;
                            exp_do = burst_q[j];
                        end
                        if (n <= 2 + p && j == n) exp_ea = 1'b1;
                        if (n > 2 + p && j == 2 + p) model_lc = model_lc + 16'd1;
                    end
                end
            end
            checkOutput(exp_fa, exp_do, exp_ew, exp_ea);
            @(negedge rxbyteclkhs);
        end
    endtask

    task automatic checkOutput(input logic exp_fa, input logic [15:0] exp_do,
                               input logic exp_ew, input logic exp_ea);
        check("frame_active", 32'(bus.frame_active), 32'(exp_fa));
        check("data_out",     32'(bus.data_out),     32'(exp_do));
        check("err_wc",       32'(bus.err_wc),       32'(exp_ew));
        check("err_abort",    32'(bus.err_abort),    32'(exp_ea));
        check("frame_valid",  32'(bus.frame_valid),  32'(model_fv));
        check("line_count",   32'(bus.line_count),   32'(model_lc));
        if (bus.frame_active) seen_fa++;
        if (bus.err_wc)       seen_ew++;
        if (bus.err_abort)    seen_ea++;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_data_out"},     32'(bus.data_out),     0);
        check({tag, "_frame_active"}, 32'(bus.frame_active), 0);
        check({tag, "_frame_valid"},  32'(bus.frame_valid),  0);
        check({tag, "_line_count"},   32'(bus.line_count),   0);
        check({tag, "_err_wc"},       32'(bus.err_wc),       0);
        check({tag, "_err_abort"},    32'(bus.err_abort),    0);
    endtask

    initial begin
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        int          pick, full, n;

        bus.data_in = '0; bus.data_valid = 1'b0; reset_n = 1'b0;
        model_fv = 1'b0; model_lc = '0;
        repeat (2) @(posedge rxbyteclkhs);
        #1;
        checkAllZero("reset");
        @(negedge rxbyteclkhs);
        reset_n = 1'b1;

        vecs[0]  = mk({16'h0000, 16'h0012, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1'b1, 16'd0, 0, 0, 0);
        vecs[1]  = mk({16'h2B0A, 16'h0055, 16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2, 16'hE1E2, 16'h1234}, 8, 1'b1, 16'd1, 5, 0, 0);
        vecs[2]  = mk({16'h2B09, 16'h0055, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 1'b1, 16'd1, 0, 1, 0);
        vecs[3]  = mk({16'h2B0A, 16'h0055, 16'h0101, 16'h0202, 16'h0303, 16'h0, 16'h0, 16'h0}, 5, 1'b1, 16'd1, 3, 0, 1);
        vecs[4]  = mk({16'h2B04, 16'h0055, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0, 16'h0, 16'h0}, 5, 1'b1, 16'd2, 2, 0, 0);
        vecs[5]  = mk({16'h1204, 16'h0055, 16'hDEAD, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 1'b1, 16'd2, 0, 0, 0);
        vecs[6]  = mk({16'h0100, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1'b0, 16'd2, 0, 0, 0);
        vecs[7]  = mk({16'h0100, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1'b0, 16'd2, 0, 0, 0);
        vecs[8]  = mk({16'h2B02, 16'h0055, 16'h5A5A, 16'hC3C3, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 1'b0, 16'd3, 1, 0, 0);
        vecs[9]  = mk({16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1'b1, 16'd0, 0, 0, 0);
        vecs[10] = mk({16'h2B0A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 1'b1, 16'd0, 0, 0, 1);
`ifdef CSI_VC_FILTER_EN
        vecs[11] = mk({16'h6B04, 16'h0055, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0}, 5, 1'b1, 16'd0, 0, 0, 0);
`else
        vecs[11] = mk({16'h6B04, 16'h0055, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0}, 5, 1'b1, 16'd1, 2, 0, 0);
`endif
        vecs[12] = mk({16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1'b1, 16'd0, 0, 0, 0);
        vecs[13] = mk({16'h2B00, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 1'b1, 16'd0, 0, 1, 0);
        vecs[14] = mk({16'h2B02, 16'h0055, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'h0, 16'h0}, 6, 1'b1, 16'd1, 1, 0, 0);

        for (int i = 0; i < 15; i++) begin
            burst_q = {};
            for (int j = 0; j < vecs[i].n; j++) burst_q.push_back(vecs[i].w[j]);
            applyStimulus(1 + int'($urandom_range(0, 2)));
            check($sformatf("vec%0d_frame_valid", i), 32'(bus.frame_valid), 32'(vecs[i].exp_fv));
            check($sformatf("vec%0d_line_count", i),  32'(bus.line_count),  32'(vecs[i].exp_lc));
            check($sformatf("vec%0d_fa_cycles", i),   seen_fa, vecs[i].exp_fa);
            check($sformatf("vec%0d_err_wc", i),      seen_ew, vecs[i].exp_ew);
            check($sformatf("vec%0d_err_abort", i),   seen_ea, vecs[i].exp_ea);
        end

        // Reset in the middle of a payload, then the still-valid stream restarts as a header.
        bus.data_valid = 1'b1;
        bus.data_in = 16'h2B0A; @(negedge rxbyteclkhs);
        bus.data_in = 16'h0055; @(negedge rxbyteclkhs);
        bus.data_in = 16'h1111; @(negedge rxbyteclkhs);
        bus.data_in = 16'h2222;
        @(posedge rxbyteclkhs);
        #1;
        check("pre_reset_frame_active", 32'(bus.frame_active), 1);
        check("pre_reset_data_out",      32'(bus.data_out),     32'h2222);
        @(negedge rxbyteclkhs);
        bus.data_in = 16'h3333;
        reset_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        model_fv = 1'b0; model_lc = '0;
        @(negedge rxbyteclkhs);
        reset_n = 1'b1;
        burst_q = {16'h2B04, 16'h0055, 16'hABCD, 16'h1357, 16'hCAFE};
        applyStimulus(2);
        check("post_reset_fa_cycles", seen_fa, 2);
        check("post_reset_line_count", 32'(bus.line_count), 1);

        for (int b = 0; b < 60; b++) begin
            vc   = 2'($urandom_range(0, 3));
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: begin dt = 6'h00; wc = 16'($urandom); end
                1: begin dt = 6'h01; wc = 16'($urandom); end
                2, 3: begin dt = DT_PIXEL; wc = 16'(2 * $urandom_range(1, 8)); end
                4: begin dt = DT_PIXEL; wc = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'(2 * $urandom_range(0, 7) + 1); end
                default: begin dt = 6'($urandom); wc = 16'($urandom_range(0, 12)); end
            endcase
            full = (pick == 2 || pick == 3) ? 3 + int'(wc) / 2 : 2 + int'($urandom_range(0, 2));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, full)) : full + int'($urandom_range(0, 1));
            burst_q = {};
            burst_q.push_back({vc, dt, wc[7:0]});
            burst_q.push_back({wc[15:8], 8'($urandom)});
            while (burst_q.size() < n) burst_q.push_back(16'($urandom));
            while (burst_q.size() > n) void'(burst_q.pop_back());
            applyStimulus(1 + int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
